// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding
// and STATUS word layout.
package irq_pkg;

    localparam logic [1:0] IRQ_ADDR_PENDING = 2'd0;
    localparam logic [1:0] IRQ_ADDR_MASK    = 2'd1;
    localparam logic [1:0] IRQ_ADDR_TRIGGER = 2'd2;
    localparam logic [1:0] IRQ_ADDR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_SVC  = 2'd2
    } irq_state_e;

    localparam int IRQ_STAT_INSVC    = 15;
    localparam int IRQ_STAT_STATE_HI = 13;
    localparam int IRQ_STAT_STATE_LO = 12;
    localparam int IRQ_STAT_VEC_HI   = 3;
    localparam int IRQ_STAT_VEC_LO   = 0;

    function automatic logic [15:0] irq_status_word(input logic       insvc,
                                                    input logic [1:0] st,
                                                    input logic [3:0] vec);
        logic [15:0] w;
        w = '0;
        w[IRQ_STAT_INSVC]                       = insvc;
        w[IRQ_STAT_STATE_HI:IRQ_STAT_STATE_LO] = st;
        w[IRQ_STAT_VEC_HI:IRQ_STAT_VEC_LO]     = vec;
        return w;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index of
// the lowest set bit.
module irq_prio_enc #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    output logic             any,
    output logic [3:0]       idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        any = 1'b0;
        idx = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                any = 1'b1;
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level latching into PENDING, masking, fixed
// lowest-index-first priority and an ack/EOI handshake with the CPU.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic             bus_clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [1:0]       addr,
    input  logic             write,
    input  logic [15:0]      bus_in,
    output logic [15:0]      bus_out,
    output logic             cpu_irq,
    input  logic             cpu_ack,
    output logic [3:0]       cpu_vec
);

    logic [N_SRC-1:0] src_prev;
    logic [N_SRC-1:0] pending, pending_d;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] trig_q;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] win_oh;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pend_edge;

    irq_state_e state_q, state_d;
    logic       cpu_irq_d;
    logic [3:0] cpu_vec_d;
    logic       in_service, in_service_d;

    logic       any;
    logic [3:0] win_idx;
    logic       eoi;
    logic       ack_take;
    logic       bus_unused;

    assign bus_unused = ^bus_in;

    assign req = pending & mask_q;

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .req (req),
        .any (any),
        .idx (win_idx)
    );

    assign eoi      = write && (addr == IRQ_ADDR_STATUS) && (state_q == IRQ_SVC);
    assign ack_take = (state_q == IRQ_REQ) && cpu_ack && any;

    // Edge bits: clear first, then a fresh rising edge overrides the clear.
    // Level bits just resample the input every cycle.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            win_oh[i] = (4'(i) == win_idx);
        end
        clr = '0;
        if (write && (addr == IRQ_ADDR_PENDING)) begin
            clr = bus_in[N_SRC-1:0];
        end
        if (ack_take) begin
            clr = clr | win_oh;
        end
        pend_edge = (pending & ~clr) | (irq_src & ~src_prev);
        pending_d = (trig_q & pend_edge) | (~trig_q & irq_src);
    end

    always_comb begin
        state_d      = state_q;
        cpu_irq_d    = cpu_irq;
        cpu_vec_d    = cpu_vec;
        in_service_d = in_service;
        case (state_q)
            IRQ_IDLE: begin
                if (any) begin
                    state_d   = IRQ_REQ;
                    cpu_irq_d = 1'b1;
                end
            end
            IRQ_REQ: begin
                if (cpu_ack) begin
                    cpu_irq_d = 1'b0;
                    if (any) begin
                        state_d      = IRQ_SVC;
                        cpu_vec_d    = win_idx;
                        in_service_d = 1'b1;
                    end else begin
                        state_d = IRQ_IDLE;
                    end
                end else if (!any) begin
                    state_d   = IRQ_IDLE;
                    cpu_irq_d = 1'b0;
                end
            end
            IRQ_SVC: begin
                if (eoi) begin
                    state_d      = IRQ_IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d      = IRQ_IDLE;
                cpu_irq_d    = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IRQ_IDLE;
            cpu_irq    <= 1'b0;
            cpu_vec    <= 4'd0;
            in_service <= 1'b0;
            src_prev   <= '0;
            pending    <= '0;
            mask_q     <= '0;
            trig_q     <= '1;
        end else begin
            state_q    <= state_d;
            cpu_irq    <= cpu_irq_d;
            cpu_vec    <= cpu_vec_d;
            in_service <= in_service_d;
            src_prev   <= irq_src;
            pending    <= pending_d;
            if (write && (addr == IRQ_ADDR_MASK)) begin
                mask_q <= bus_in[N_SRC-1:0];
            end
            if (write && (addr == IRQ_ADDR_TRIGGER)) begin
                trig_q <= bus_in[N_SRC-1:0];
            end
        end
    end

    always_comb begin
        bus_out = '0;
        case (addr)
            IRQ_ADDR_PENDING: bus_out[N_SRC-1:0] = pending;
            IRQ_ADDR_MASK:    bus_out[N_SRC-1:0] = mask_q;
            IRQ_ADDR_TRIGGER: bus_out[N_SRC-1:0] = trig_q;
            default:          bus_out = irq_status_word(in_service, state_q, cpu_vec);
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_irq_ctrl;

    localparam int N_SRC = 8;

    logic             bus_clk = 1'b0;
    logic             rst_n   = 1'b0;
    logic [N_SRC-1:0] irq_src = '0;
    logic [1:0]       addr    = 2'd0;
    logic             write   = 1'b0;
    logic [15:0]      bus_in  = 16'd0;
    logic [15:0]      bus_out;
    logic             cpu_irq;
    logic             cpu_ack = 1'b0;
    logic [3:0]       cpu_vec;

    irq_ctrl #(.N_SRC(N_SRC)) dut (
        .bus_clk (bus_clk),
        .rst_n   (rst_n),
        .irq_src (irq_src),
        .addr    (addr),
        .write   (write),
        .bus_in  (bus_in),
        .bus_out (bus_out),
        .cpu_irq (cpu_irq),
        .cpu_ack (cpu_ack),
        .cpu_vec (cpu_vec)
    );

    always #5 bus_clk = ~bus_clk;

    int cyc = 0;
    always @(posedge bus_clk) cyc <= cyc + 1;

    localparam int K_BUS = 0;
    localparam int K_IRQ = 1;
    localparam int K_VEC = 2;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] act;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(negedge bus_clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_BUS:   act = bus_out;
                K_IRQ:   act = {15'd0, cpu_irq};
                default: act = {12'd0, cpu_vec};
            endcase
            n_cmp++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got 0x%04h, expected 0x%04h (cycle %0d, due %0d)",
                         e.name, act, e.exp, cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic exp_push(input int kind, input logic [15:0] v, input string name);
        exp_t x;
        x.cyc  = cyc;
        x.kind = kind;
        x.exp  = v;
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] v, input string name);
        addr = a;
        exp_push(K_BUS, v, name);
        tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        addr   = a;
        bus_in = d;
        write  = 1'b1;
        tick();
        write  = 1'b0;
        bus_in = 16'd0;
    endtask

    task automatic pulse(input logic [N_SRC-1:0] s);
        irq_src = s;
        tick();
        irq_src = '0;
    endtask

    task automatic ack();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        exp_push(K_IRQ, 16'd0, "rst_irq");
        exp_push(K_VEC, 16'd0, "rst_vec");
        rd(2'd0, 16'h0000, "rst_pending");
        rd(2'd1, 16'h0000, "rst_mask");
        rd(2'd2, 16'h00FF, "rst_trigger");
        rd(2'd3, 16'h0000, "rst_status");

        // 1: single edge source, ack, EOI
        wr(2'd1, 16'h0001);
        pulse(8'h01);
        exp_push(K_IRQ, 16'd0, "t1_irq_not_yet");
        rd(2'd0, 16'h0001, "t1_pending");
        exp_push(K_IRQ, 16'd1, "t1_irq_raised");
        tick();
        tick();
        ack();
        exp_push(K_VEC, 16'd0, "t1_vec");
        exp_push(K_IRQ, 16'd0, "t1_irq_after_ack");
        rd(2'd0, 16'h0000, "t1_pending_cleared");
        rd(2'd3, 16'hA000, "t1_status_svc");
        wr(2'd3, 16'h0000);
        rd(2'd3, 16'h0000, "t1_status_after_eoi");

        // 2: two simultaneous sources, priority order
        wr(2'd1, 16'h00FF);
        pulse(8'h24);
        tick();
        exp_push(K_IRQ, 16'd1, "t2_irq");
        ack();
        exp_push(K_VEC, 16'd2, "t2_vec_first");
        exp_push(K_IRQ, 16'd0, "t2_irq_after_ack");
        rd(2'd0, 16'h0020, "t2_pending_left");
        rd(2'd3, 16'hA002, "t2_status_svc");
        wr(2'd3, 16'h0000);
        exp_push(K_IRQ, 16'd0, "t2_irq_eoi_cycle");
        rd(2'd3, 16'h0002, "t2_status_idle");
        exp_push(K_IRQ, 16'd1, "t2_irq_rereq");
        ack();
        exp_push(K_VEC, 16'd5, "t2_vec_second");
        rd(2'd0, 16'h0000, "t2_pending_empty");
        wr(2'd3, 16'h0000);

        // 3: level source held high
        wr(2'd2, 16'h00FE);
        wr(2'd1, 16'h0001);
        irq_src = 8'h01;
        tick();
        tick();
        exp_push(K_IRQ, 16'd1, "t3_irq");
        ack();
        exp_push(K_VEC, 16'd0, "t3_vec");
        exp_push(K_IRQ, 16'd0, "t3_irq_after_ack");
        rd(2'd0, 16'h0001, "t3_level_pending");
        wr(2'd3, 16'h0000);
        exp_push(K_IRQ, 16'd0, "t3_irq_eoi_cycle");
        tick();
        exp_push(K_IRQ, 16'd1, "t3_irq_reassert");
        wr(2'd0, 16'h0001);
        rd(2'd0, 16'h0001, "t3_w1c_no_effect");
        irq_src = 8'h00;
        tick();
        tick();
        exp_push(K_IRQ, 16'd0, "t3_irq_withdrawn");
        wr(2'd2, 16'h00FF);

        // 4: mask drop while requesting, late ack ignored
        wr(2'd1, 16'h0002);
        pulse(8'h02);
        tick();
        exp_push(K_IRQ, 16'd1, "t4_irq");
        wr(2'd1, 16'h0000);
        exp_push(K_IRQ, 16'd1, "t4_irq_still_up");
        tick();
        exp_push(K_IRQ, 16'd0, "t4_irq_dropped");
        ack();
        exp_push(K_VEC, 16'd0, "t4_vec_unchanged");
        rd(2'd3, 16'h0000, "t4_status_idle");
        rd(2'd0, 16'h0002, "t4_pending_kept");
        wr(2'd0, 16'h0002);
        rd(2'd0, 16'h0000, "t4_w1c_clears");

        // 5: set beats W1C; stuck-high edge pends once
        irq_src = 8'h08;
        wr(2'd0, 16'h0008);
        irq_src = 8'h00;
        rd(2'd0, 16'h0008, "t5_set_wins");
        wr(2'd0, 16'h0008);
        rd(2'd0, 16'h0000, "t5_w1c");
        irq_src = 8'h04;
        tick();
        rd(2'd0, 16'h0004, "t5_stuck_pend");
        wr(2'd0, 16'h0004);
        rd(2'd0, 16'h0000, "t5_stuck_once");
        irq_src = 8'h00;

        // 6: asynchronous reset in SERVICE
        wr(2'd1, 16'h0008);
        pulse(8'h08);
        tick();
        ack();
        exp_push(K_VEC, 16'd3, "t6_vec");
        rd(2'd3, 16'hA003, "t6_status_svc");
        rst_n = 1'b0;
        exp_push(K_IRQ, 16'd0, "t6_rst_irq");
        exp_push(K_VEC, 16'd0, "t6_rst_vec");
        rd(2'd3, 16'h0000, "t6_rst_status");
        rd(2'd1, 16'h0000, "t6_rst_mask");
        rd(2'd2, 16'h00FF, "t6_rst_trigger");
        rd(2'd0, 16'h0000, "t6_rst_pending");
        rst_n = 1'b1;

        tick();
        tick();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
            n_cmp = n_cmp + sb.size();
            n_bad = n_bad + sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
